uart_transmitter: RTL and testbench

Serial UART transmitter that drives the `txd` line from bytes handed over one at a time by the UART controller's transmit side (`trans_data` / `trans_ok` / `trans_busy`). It is the far end of that handshake. It frames each byte as:

- one start bit;
- 8 data bits, LSB first;
- `STOP_BITS` stop bits.

Each bit lasts `CLK_PER_BIT` clock cycles. It sits between the controller's transmit FIFO and the board TX pin.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_transmitter.sv | 130 +++++++++++++
 tb/tb_uart_transmitter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM state encoding and framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running 0..CLK_PER_BIT-1 counter, tick on the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              W    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [W-1:0]    LAST = W'(CLK_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  // Clear restarts the bit so the start bit gets its full length
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= W'(0);
    end else if (r_cnt == LAST) begin
      r_cnt <= W'(0);
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits on a registered txd.
// busy includes the incoming ok so the controller sees it on the accepting edge.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ok,
  output logic       busy,
  output logic       txd
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_tx_state_t            r_state, w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [2:0]                r_bit_idx, w_bit_idx_next;
  logic                      r_stop_idx, w_stop_idx_next;
  logic                      r_txd, w_txd_next;
  logic                      w_accept;
  logic                      w_tick;

  assign w_accept = (r_state == IDLE) && ok;

  uart_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_accept),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers follow the next-state values so txd lines up with the state it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= 8'h00;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_txd      <= w_txd_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    case (r_state)
      IDLE: begin
        if (ok) begin
          w_state_next    = START;
          w_shift_next    = data;
          w_bit_idx_next  = 3'd0;
          w_stop_idx_next = 1'b0;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = 3'd0;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit_idx == LAST_DATA) begin
            w_state_next    = STOP;
            w_stop_idx_next = 1'b0;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop_idx == LAST_STOP) begin
            w_state_next = IDLE;
          end else begin
            w_stop_idx_next = r_stop_idx + 1'b1;
          end
        end else begin
          w_state_next = STOP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      IDLE:    w_txd_next = 1'b1;
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[0];
      STOP:    w_txd_next = 1'b1;
      default: w_txd_next = 1'b1;
    endcase
  end

  assign busy = (r_state != IDLE) || ok;
  assign txd  = r_txd;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: DUT A with CLK_PER_BIT=4/1 stop bit, DUT B with CLK_PER_BIT=3/2 stop bits.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a = 8'h00;
  logic       ok_a = 1'b0;
  logic       busy_a;
  logic       txd_a;
  logic [7:0] data_b = 8'h00;
  logic       ok_b = 1'b0;
  logic       busy_b;
  logic       txd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLK_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .data(data_a), .ok(ok_a), .busy(busy_a), .txd(txd_a)
  );

  uart_transmitter #(.CLK_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .ok(ok_b), .busy(busy_b), .txd(txd_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ok_a  = 1'b1;
    data_a = 8'h00;
    step();
    step();
    reset = 1'b0;
    ok_a  = 1'b0;
    #1;
    n_tests++;
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd_a); end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_tests++;
    if (txd_b !== 1'b1) begin n_fail++; $display("FAIL reset_txd_b: got %b want 1", txd_b); end
    n_tests++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    step();
    n_tests++;
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL reset_ok_ignored: txd got %b want 1", txd_a); end
  endtask

  task automatic test_comb_busy();
    ok_a = 1'b1;
    #1;
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL comb_busy_high: got %b want 1", busy_a); end
    ok_a = 1'b0;
    #1;
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL comb_busy_low: got %b want 0", busy_a); end
    step();
    n_tests++;
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL comb_busy_no_frame: txd got %b want 1", txd_a); end
  endtask

  task automatic test_single();
    logic [9:0] exp_bits;
    exp_bits = 10'b1_01010101_0;
    data_a = 8'h55;
    ok_a   = 1'b1;
    #1;
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_e0: got %b want 1", busy_a); end
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if (txd_a !== exp_bits[c/4]) begin
        n_fail++; $display("FAIL single_txd: cycle %0d got %b want %b", c, txd_a, exp_bits[c/4]);
      end
      n_tests++;
      if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy: cycle %0d got %b want 1", c, busy_a); end
      step();
    end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy_a); end
    n_tests++;
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL single_txd_end: got %b want 1", txd_a); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_bits;
    exp_bits = {10'b1_00000000_0, 10'b1_10100011_0};
    data_a = 8'hA3;
    ok_a   = 1'b1;
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if (txd_a !== exp_bits[c/4]) begin
        n_fail++; $display("FAIL b2b_first_txd: cycle %0d got %b want %b", c, txd_a, exp_bits[c/4]);
      end
      step();
    end
    // First cycle busy is low: request the second byte right away
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_drop: got %b want 0", busy_a); end
    data_a = 8'h00;
    ok_a   = 1'b1;
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if (txd_a !== exp_bits[10 + c/4]) begin
        n_fail++; $display("FAIL b2b_second_txd: cycle %0d got %b want %b", c, txd_a, exp_bits[10 + c/4]);
      end
      step();
    end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy_a); end
  endtask

  task automatic test_request_while_busy();
    logic [9:0] exp_bits;
    exp_bits = 10'b1_11111111_0;
    data_a = 8'hFF;
    ok_a   = 1'b1;
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) begin
        data_a = 8'h00;
        ok_a   = 1'b1;
      end else begin
        ok_a = 1'b0;
      end
      n_tests++;
      if (txd_a !== exp_bits[c/4]) begin
        n_fail++; $display("FAIL busy_req_txd: cycle %0d got %b want %b", c, txd_a, exp_bits[c/4]);
      end
      step();
    end
    ok_a = 1'b0;
    for (int c = 0; c < 50; c++) begin
      n_tests++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
        n_fail++; $display("FAIL busy_req_idle: cycle %0d txd %b busy %b want 1/0", c, txd_a, busy_a);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp_bits;
    exp_bits = 10'b1_10000001_0;
    data_a = 8'h0F;
    ok_a   = 1'b1;
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 17; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL midreset_txd: got %b want 1", txd_a); end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
    step();
    step();
    data_a = 8'h81;
    ok_a   = 1'b1;
    step();
    ok_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if (txd_a !== exp_bits[c/4]) begin
        n_fail++; $display("FAIL midreset_frame_txd: cycle %0d got %b want %b", c, txd_a, exp_bits[c/4]);
      end
      step();
    end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_end: got %b want 0", busy_a); end
  endtask

  task automatic test_two_stop_bits();
    logic [10:0] exp_bits;
    exp_bits = 11'b11_10000000_0;
    data_b = 8'h80;
    ok_b   = 1'b1;
    step();
    ok_b = 1'b0;
    for (int c = 0; c < 33; c++) begin
      n_tests++;
      if (txd_b !== exp_bits[c/3] || busy_b !== 1'b1) begin
        n_fail++; $display("FAIL two_stop_frame: cycle %0d txd %b busy %b want %b/1", c, txd_b, busy_b, exp_bits[c/3]);
      end
      step();
    end
    n_tests++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL two_stop_busy_end: got %b want 0", busy_b); end
    n_tests++;
    if (txd_b !== 1'b1) begin n_fail++; $display("FAIL two_stop_txd_end: got %b want 1", txd_b); end
  endtask

  initial begin
    test_reset();
    test_comb_busy();
    test_single();
    step();
    test_back_to_back();
    step();
    test_request_while_busy();
    test_reset_mid_frame();
    step();
    test_two_stop_bits();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
